bin_bcd_seq: RTL
================

BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, operand width in bits (W >= 2).
REQ-002 The block SHALL have parameter D, default 4, number of BCD output digits (D >= 1).
REQ-003 The block SHALL use one clock, clk; every flop SHALL update on its rising edge.
REQ-004 The block SHALL use reset rst_n, asynchronous and active-low.
REQ-005 Port clk: input, 1 bit, system clock.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port start: input, 1 bit, request to convert operand; sampled only in IDLE.
REQ-008 Port operand: input, W bits, binary value to convert.
REQ-009 Port is_signed: input, 1 bit, 1 = treat operand as two's complement.
REQ-010 Port busy: output, 1 bit, conversion in progress.
REQ-011 Port done: output, 1 bit, one-cycle pulse when a result is valid.
REQ-012 Port bcd: output, packed [D-1:0][3:0], digit 0 = units, each digit 0..9; this port is the digit-array input of the display decoder stage.
REQ-013 Port neg: output, 1 bit, result sign (1 = negative).
REQ-014 Port ovf: output, 1 bit, magnitude exceeds 10^D-1.

Function
REQ-015 The block SHALL be an FSM with states IDLE and SHIFT. It SHALL convert using iterative shift-add-3 (double dabble), one operand bit per cycle.
REQ-016 In IDLE with start=1 at a rising edge, the block SHALL take these actions:
- latch mag = |operand| if is_signed=1 and operand[W-1]=1, otherwise mag = operand;
- latch sign_r = is_signed & operand[W-1];
- clear the internal BCD shift register and the overflow sticky bit;
- load bit counter = W;
- go to SHIFT and set busy=1.
REQ-017 The magnitude SHALL be computed in W+1 bits so that operand = -2^(W-1) converts to 2^(W-1) without error.
REQ-018 Each SHIFT cycle SHALL execute these steps in order:
- add 3 to every internal digit >= 5;
- shift {digits, mag} left by one, inserting the mag MSB into digit 0;
- decrement the counter.
REQ-019 A 1 shifted out of the top digit SHALL set the overflow sticky bit; lower digits SHALL remain the exact low D decimal digits of the value.
REQ-020 On the SHIFT edge that processes the last bit, the block SHALL take these actions:
- load bcd with the final digits, neg with sign_r & (magnitude != 0), and ovf with the sticky bit;
- assert done for exactly that following cycle;
- deassert busy;
- return to IDLE.
REQ-021 Latency SHALL be fixed: done rises on the W+1th rising edge counting the start-sampling edge as edge 1 (W = 8 gives 9 edges). Throughput SHALL be one conversion per W+1 cycles.
REQ-022 While busy=1, start SHALL be ignored, and operand and is_signed changes SHALL NOT affect the result in progress.
REQ-023 start=1 in the cycle where done=1 SHALL be accepted (state is IDLE), giving back-to-back conversions.
REQ-024 bcd, neg and ovf SHALL hold their values from the last completed conversion until the next done; they SHALL NOT change during SHIFT.
REQ-025 done SHALL never be asserted for two consecutive cycles. busy and done SHALL never be high simultaneously.
REQ-026 Zero input SHALL yield bcd = 0, neg = 0, ovf = 0, including signed zero.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, independent of clk:
- state = IDLE;
- busy = 0, done = 0;
- bcd = 0, neg = 0, ovf = 0;
- counter and internal registers = 0.
REQ-028 Reset asserted during SHIFT SHALL abort the conversion with no done pulse; after release the first start SHALL begin a clean conversion.
REQ-029 The block SHALL respond to start on the first rising edge after rst_n deasserts.

Verification
REQ-030 Unsigned max: W=8, D=4, operand=8'hFF, is_signed=0, start pulse -> done on edge 9 after start, bcd=16'h0255, neg=0, ovf=0, busy high for 8 cycles.
REQ-031 Signed extremes:
- operand=8'h80, is_signed=1 -> bcd=16'h0128, neg=1;
- operand=8'hFF, is_signed=1 -> bcd=16'h0001, neg=1;
- operand=8'h00, is_signed=1 -> bcd=0, neg=0.
REQ-032 Handshake:
- start re-pulsed with operand=8'd99 in cycle 3 of a conversion of 8'd42 -> result 16'h0042, no extra done;
- start held in the done cycle with 8'd7 -> second done exactly 9 cycles later with 16'h0007.
REQ-033 Overflow: W=16, D=4, operand=16'hFFFF, is_signed=0 -> bcd=16'h5535, ovf=1; a following operand=16'd9999 -> bcd=16'h9999, ovf=0.
REQ-034 Reset mid-operation: rst_n pulsed low at SHIFT cycle 4 of a conversion of 8'd200 -> outputs 0 immediately, no done; a new start with 8'd200 -> bcd=16'h0200 after 9 edges.
REQ-035 Random: 10k random operand/is_signed pairs compared against a reference model -> bcd, neg and ovf all match, and every digit <= 9.

Source files
------------

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// Converts one operand bit per clock and can take signed or unsigned input.
module bin_bcd_seq #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W-1:0]       operand,
    input  logic               is_signed,
    output logic               busy,
    output logic               done,
    output logic [D-1:0][3:0]  bcd,
    output logic               neg,
    output logic               ovf
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q;
    logic [W-1:0]        mag_q;
    logic [D-1:0][3:0]   dig_q;
    logic [CW-1:0]       cnt_q;
    logic                sign_q;
    logic                nz_q;
    logic                sticky_q;
    logic                busy_q;
    logic                done_q;
    logic [D-1:0][3:0]   bcd_q;
    logic                neg_q;
    logic                ovf_q;

    logic [W:0]          mag_ext;
    logic [D-1:0][3:0]   adj;
    logic [4*D:0]        shifted;
    logic [D-1:0][3:0]   dig_d;
    logic                carry_out;

    // Magnitude is formed one bit wider so that -2^(W-1) negates cleanly.
    always_comb begin
        mag_ext = {1'b0, operand};
        if (is_signed && operand[W-1]) begin
            mag_ext = ~{operand[W-1], operand} + 1'b1;
        end
        for (int i = 0; i < D; i++) begin
            adj[i] = (dig_q[i] >= 4'd5) ? dig_q[i] + 4'd3 : dig_q[i];
        end
        shifted   = {adj, mag_q[W-1]};
        carry_out = shifted[4*D];
        dig_d     = shifted[4*D-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            nz_q     <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_q    <= mag_ext[W-1:0];
                        sign_q   <= is_signed & operand[W-1];
                        nz_q     <= |mag_ext;
                        dig_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CW'(W);
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    dig_q    <= dig_d;
                    mag_q    <= {mag_q[W-2:0], 1'b0};
                    sticky_q <= sticky_q | carry_out;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= dig_d;
                        neg_q   <= sign_q & nz_q;
                        ovf_q   <= sticky_q | carry_out;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule
